// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder with valid/ready handshakes on both sides.
// Optional macro PREFIX_ADDER_SUB_EN adds the in_sub port (per-beat a + ~b + 1).
module prefix_adder_pipe #(
  parameter int WIDTH       = 16,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
`ifdef PREFIX_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int LAST   = PIPE_STAGES - 1;

  logic [WIDTH-1:0]       gQ   [PIPE_STAGES];
  logic [WIDTH-1:0]       pQ   [PIPE_STAGES];
  logic [WIDTH-1:0]       p0Q  [PIPE_STAGES];
  logic [TAG_W-1:0]       tagQ [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] cinQ;
  logic [PIPE_STAGES-1:0] validQ;
  logic [WIDTH-1:0]       sumQ;
  logic                   coutQ;
  logic                   ovfQ;

  logic [WIDTH-1:0]       gIn   [PIPE_STAGES];
  logic [WIDTH-1:0]       pIn   [PIPE_STAGES];
  logic [WIDTH-1:0]       p0In  [PIPE_STAGES];
  logic [TAG_W-1:0]       tagIn [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] cinIn;
  logic [PIPE_STAGES-1:0] validIn;
  logic [PIPE_STAGES-1:0] canLoad;
  logic [WIDTH-1:0]       gD [PIPE_STAGES];
  logic [WIDTH-1:0]       pD [PIPE_STAGES];
  logic [WIDTH-1:0]       sumD;
  logic                   coutD;
  logic                   ovfD;
  logic [WIDTH-1:0]       bEff;
  logic                   cinEff;

`ifdef PREFIX_ADDER_SUB_EN
  assign bEff   = in_sub ? ~in_b : in_b;
  assign cinEff = in_sub | in_cin;
`else
  assign bEff   = in_b;
  assign cinEff = in_cin;
`endif

  // Carry-in is folded into bit 0's generate so the tree needs no extra level.
  always_comb begin
    p0In[0]    = in_a ^ bEff;
    gIn[0]     = in_a & bEff;
    gIn[0][0]  = gIn[0][0] | (p0In[0][0] & cinEff);
    pIn[0]     = p0In[0];
    cinIn[0]   = cinEff;
    tagIn[0]   = in_tag;
    validIn[0] = in_valid;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      gIn[k]     = gQ[k-1];
      pIn[k]     = pQ[k-1];
      p0In[k]    = p0Q[k-1];
      cinIn[k]   = cinQ[k-1];
      tagIn[k]   = tagQ[k-1];
      validIn[k] = validQ[k-1];
    end
    for (int k = 0; k < PIPE_STAGES; k++) begin
      gD[k] = gIn[k];
      pD[k] = pIn[k];
      for (int lv = 0; lv < LEVELS; lv++) begin
        if (lv >= (k * LEVELS) / PIPE_STAGES && lv < ((k + 1) * LEVELS) / PIPE_STAGES) begin
          for (int i = WIDTH - 1; i >= (1 << lv); i--) begin
            gD[k][i] = gD[k][i] | (pD[k][i] & gD[k][i - (1 << lv)]);
            pD[k][i] = pD[k][i] & pD[k][i - (1 << lv)];
          end
        end
      end
    end
  end

  assign sumD  = p0In[LAST] ^ {gD[LAST][WIDTH-2:0], cinIn[LAST]};
  assign coutD = gD[LAST][WIDTH-1];
  assign ovfD  = gD[LAST][WIDTH-1] ^ gD[LAST][WIDTH-2];

  // A stage may load when empty or when its contents move on this cycle.
  always_comb begin
    canLoad       = '0;
    canLoad[LAST] = !validQ[LAST] || out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      canLoad[k] = !validQ[k] || canLoad[k+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ <= '0;
      cinQ   <= '0;
      sumQ   <= '0;
      coutQ  <= 1'b0;
      ovfQ   <= 1'b0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        gQ[k]   <= '0;
        pQ[k]   <= '0;
        p0Q[k]  <= '0;
        tagQ[k] <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (canLoad[k]) begin
          validQ[k] <= validIn[k];
          if (validIn[k]) begin
            gQ[k]   <= gD[k];
            pQ[k]   <= pD[k];
            p0Q[k]  <= p0In[k];
            cinQ[k] <= cinIn[k];
            tagQ[k] <= tagIn[k];
          end
        end
      end
      if (canLoad[LAST] && validIn[LAST]) begin
        sumQ  <= sumD;
        coutQ <= coutD;
        ovfQ  <= ovfD;
      end
    end
  end

  assign in_ready  = canLoad[0];
  assign out_valid = validQ[LAST];
  assign out_sum   = sumQ;
  assign out_cout  = coutQ;
  assign out_ovf   = ovfQ;
  assign out_tag   = tagQ[LAST];

endmodule
